apb_i2c_master: RTL and testbench

- Register-mapped I2C master on the memory-side port of the APB slave; it sits where the memory would otherwise sit.
- The APB slave issues ce/wren/rden/addr/wdata strobes; this block decodes them into control/data registers and runs single-byte I2C write or read transactions on SCL/SDA.
- Each transaction is START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.

---
 rtl/apb_i2c_master.sv | 163 ++++++++++++++++
 tb/tb_apb_i2c_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_master.sv
// Register-mapped single-byte I2C master sitting on the memory-side port of an APB slave.
// Runs START, address+R/W, ACK, one data byte, ACK/NACK and STOP, with each bit split into four quarters.
module apb_i2c_master #(
  parameter int unsigned DIV_DEFAULT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RNACK, S_STOP
  } state_e;

  state_e      st_q, st_d;
  logic [1:0]  qt_q, qt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  cnt_q, cnt_d, divc_q, divc_d;
  logic [7:0]  sh_q, sh_d, tx_sh_q, tx_sh_d, rx_q, rx_d;
  logic        ack_q, ack_d, rw_sh_q, rw_sh_d;
  logic        rw_q, rw_d, done_q, done_d, ackerr_q, ackerr_d;
  logic [6:0]  saddr_q, saddr_d;
  logic [7:0]  txdata_q, txdata_d, clkdiv_q, clkdiv_d;
  logic [7:0]  rd_mux, div_eff;
  logic [1:0]  drv;
  logic        busy, wr_en, start_go;

  assign busy     = (st_q != S_IDLE);
  assign wr_en    = ce && wren;
  assign start_go = wr_en && (addr == 8'h00) && wdata[0] && !busy;
  assign div_eff  = (clkdiv_q == 8'd0) ? 8'd1 : clkdiv_q;

  // Line levels {scl, sda_oe} for a given position inside the transaction.
  function automatic logic [1:0] drive(state_e s, logic [1:0] q, logic b);
    logic cell_scl;
    cell_scl = (q == 2'd1) || (q == 2'd2);
    case (s)
      S_IDLE:           drive = 2'b10;
      S_START:          drive = {q != 2'd3, q != 2'd0};
      S_ADDR, S_WDATA:  drive = {cell_scl, ~b};
      S_STOP:           drive = {q != 2'd0, q < 2'd2};
      default:          drive = {cell_scl, 1'b0};
    endcase
  endfunction

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      8'h00:   rd_mux = {6'd0, rw_q, 1'b0};
      8'h01:   rd_mux = {1'b0, saddr_q};
      8'h02:   rd_mux = txdata_q;
      8'h03:   rd_mux = rx_q;
      8'h04:   rd_mux = {5'd0, ackerr_q, done_q, busy};
      8'h05:   rd_mux = clkdiv_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    st_d = st_q;   qt_d = qt_q;     bit_d = bit_q;     cnt_d = cnt_q;
    divc_d = divc_q; sh_d = sh_q;   ack_d = ack_q;     rx_d = rx_q;
    rw_sh_d = rw_sh_q; tx_sh_d = tx_sh_q; rw_d = rw_q; saddr_d = saddr_q;
    txdata_d = txdata_q; clkdiv_d = clkdiv_q; done_d = done_q; ackerr_d = ackerr_q;

    if (wr_en) begin
      case (addr)
        8'h00: if (!(wdata[0] && busy)) rw_d = wdata[1];
        8'h01: saddr_d  = wdata[6:0];
        8'h02: txdata_d = wdata;
        8'h04: begin
          if (wdata[1]) done_d   = 1'b0;
          if (wdata[2]) ackerr_d = 1'b0;
        end
        8'h05: clkdiv_d = wdata;
        default: ;
      endcase
    end

    if (st_q == S_IDLE) begin
      if (start_go) begin
        st_d     = S_START;
        qt_d     = 2'd0;
        bit_d    = 3'd0;
        cnt_d    = 8'd0;
        divc_d   = div_eff;
        sh_d     = {saddr_q, wdata[1]};
        rw_sh_d  = wdata[1];
        tx_sh_d  = txdata_q;
        done_d   = 1'b0;
        ackerr_d = 1'b0;
      end
    end else if (cnt_q == divc_q - 8'd1) begin
      cnt_d  = 8'd0;
      divc_d = div_eff;
      qt_d   = qt_q + 2'd1;
      if (qt_q == 2'd2) begin
        ack_d = sda_i;
        if (st_q == S_RDATA) sh_d = {sh_q[6:0], sda_i};
      end
      if (qt_q == 2'd3) begin
        case (st_q)
          S_START: begin st_d = S_ADDR; bit_d = 3'd0; end
          S_ADDR, S_WDATA: begin
            if (bit_q == 3'd7) st_d = (st_q == S_ADDR) ? S_AACK : S_WACK;
            else begin bit_d = bit_q + 3'd1; sh_d = {sh_q[6:0], 1'b0}; end
          end
          S_AACK: begin
            bit_d = 3'd0;
            if (ack_q) begin ackerr_d = 1'b1; st_d = S_STOP; end
            else if (rw_sh_q) st_d = S_RDATA;
            else begin st_d = S_WDATA; sh_d = tx_sh_q; end
          end
          S_WACK: begin
            if (ack_q) ackerr_d = 1'b1;
            st_d = S_STOP;
          end
          S_RDATA: begin
            if (bit_q == 3'd7) begin st_d = S_RNACK; rx_d = sh_q; end
            else bit_d = bit_q + 3'd1;
          end
          S_RNACK: st_d = S_STOP;
          S_STOP:  begin st_d = S_IDLE; done_d = 1'b1; end
          default: st_d = S_IDLE;
        endcase
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign drv = drive(st_d, qt_d, sh_d[7]);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;  qt_q <= 2'd0;   bit_q <= 3'd0;   cnt_q <= 8'd0;
      divc_q <= 8'd1;  sh_q <= 8'd0;   ack_q <= 1'b0;   rx_q <= 8'd0;
      rw_sh_q <= 1'b0; tx_sh_q <= 8'd0; rw_q <= 1'b0;  saddr_q <= 7'd0;
      txdata_q <= 8'd0; clkdiv_q <= 8'(DIV_DEFAULT);
      done_q <= 1'b0;  ackerr_q <= 1'b0;
      rdata <= 8'h00;  scl_o <= 1'b1;  sda_oe <= 1'b0;
    end else begin
      st_q <= st_d;    qt_q <= qt_d;   bit_q <= bit_d;  cnt_q <= cnt_d;
      divc_q <= divc_d; sh_q <= sh_d;  ack_q <= ack_d;  rx_q <= rx_d;
      rw_sh_q <= rw_sh_d; tx_sh_q <= tx_sh_d; rw_q <= rw_d; saddr_q <= saddr_d;
      txdata_q <= txdata_d; clkdiv_q <= clkdiv_d;
      done_q <= done_d; ackerr_q <= ackerr_d;
      scl_o  <= drv[1];
      sda_oe <= drv[0];
      if (ce && rden && !wren) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_apb_i2c_master.sv
// Directed bench for apb_i2c_master: register map, write/read/NACK transactions, ignored restart,
// CLKDIV=0 timing and asynchronous reset, against a small open-drain slave model.
module tb_apb_i2c_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata;
  logic       scl_o, sda_oe;
  logic       sda_line;
  logic       slave_pull = 1'b0;

  logic       ack_en = 1'b1, rd_mode = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  logic       bits_q [0:255];
  logic       oe_q   [0:255];
  int         bit_cnt = 0;
  int         start_idx = 0;
  int         rel;

  int n_checks = 0;
  int n_errs   = 0;

  assign sda_line = !(sda_oe || slave_pull);

  always #5 clk = ~clk;

  apb_i2c_master #(.DIV_DEFAULT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .wren   (wren),
    .rden   (rden),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .scl_o  (scl_o),
    .sda_oe (sda_oe),
    .sda_i  (sda_line)
  );

  // Bus monitor: record the SDA level and master drive at every SCL rise.
  always @(posedge scl_o) begin
    if (bit_cnt < 256) begin
      bits_q[bit_cnt] = sda_line;
      oe_q[bit_cnt]   = sda_oe;
    end
    bit_cnt++;
  end

  always @(negedge sda_line) if (scl_o === 1'b1) start_idx = bit_cnt;

  // Slave: on each SCL fall, set up the level for the next bit (rel = its index).
  always @(negedge scl_o) begin
    rel = bit_cnt - start_idx;
    if (rel == 8)                               slave_pull = ack_en;
    else if (rd_mode && rel >= 9 && rel <= 16)  slave_pull = ~rd_byte[16 - rel];
    else if (!rd_mode && rel == 17)             slave_pull = ack_en;
    else                                        slave_pull = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++)
      if (base + k < 256) b[7-k] = bits_q[base + k];
    return b;
  endfunction

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; rden = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; rden = 1'b1; wren = 1'b0; addr = a;
    @(negedge clk);
    ce = 1'b0; rden = 1'b0;
    d = rdata;
  endtask

  // Writes CTRL, then polls STATUS every cycle counting BUSY cycles; optionally
  // injects a CTRL=0x01 write (with rden still high) after inject_at busy cycles.
  task automatic run_txn(input logic [7:0] ctrl, input int inject_at,
                         output int cycles, output logic [7:0] status);
    bit fin;
    fin = 1'b0;
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; rden = 1'b0; addr = 8'h00; wdata = ctrl;
    @(negedge clk);
    wren = 1'b0; rden = 1'b1; addr = 8'h04;
    cycles = 0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      @(negedge clk);
      wren = 1'b0; addr = 8'h04;
      if (rdata[0]) begin
        cycles++;
        if (cycles == inject_at) begin
          wren = 1'b1; addr = 8'h00; wdata = 8'h01;
        end
      end else begin
        fin = 1'b1;
      end
    end
    ce = 1'b0; rden = 1'b0; wren = 1'b0;
    status = rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, st;
    int cyc;

    repeat (3) @(negedge clk);
    check("rst_scl", scl_o, 1);
    check("rst_sda_oe", sda_oe, 0);
    reset = 1'b1;

    // Register map after reset
    for (int a = 0; a <= 6; a++) begin
      reg_rd(8'(a), d);
      check($sformatf("rst_reg%0d", a), d, (a == 5) ? 8'h04 : 8'h00);
    end
    check("idle_scl", scl_o, 1);
    check("idle_sda_oe", sda_oe, 0);

    // Write transaction
    reg_wr(8'h01, 8'h50);
    reg_wr(8'h02, 8'hA5);
    run_txn(8'h01, 0, cyc, st);
    check("wr_busy_cycles", cyc, 320);
    check("wr_status", st, 8'h02);
    check("wr_addr_byte", byte_at(start_idx), 8'hA0);
    check("wr_aack", bits_q[start_idx + 8], 0);
    check("wr_data_byte", byte_at(start_idx + 9), 8'hA5);
    check("wr_wack", bits_q[start_idx + 17], 0);
    check("wr_scl_rises", bit_cnt - start_idx, 19);

    // Read transaction
    rd_mode = 1'b1; rd_byte = 8'h96;
    reg_wr(8'h01, 8'h3C);
    run_txn(8'h03, 0, cyc, st);
    check("rd_busy_cycles", cyc, 320);
    check("rd_status", st, 8'h02);
    check("rd_addr_byte", byte_at(start_idx), 8'h79);
    check("rd_nack_line", bits_q[start_idx + 17], 1);
    check("rd_nack_oe", oe_q[start_idx + 17], 0);
    reg_rd(8'h03, d);
    check("rd_rxdata", d, 8'h96);

    // Address NACK (no slave)
    rd_mode = 1'b0; ack_en = 1'b0;
    run_txn(8'h01, 0, cyc, st);
    check("nack_busy_cycles", cyc, 176);
    check("nack_status", st, 8'h06);
    check("nack_scl_rises", bit_cnt - start_idx, 10);
    reg_wr(8'h04, 8'h06);
    reg_rd(8'h04, d);
    check("status_w1c", d, 8'h00);

    // Restart attempt while busy must be ignored
    ack_en = 1'b1;
    reg_wr(8'h01, 8'h50);
    run_txn(8'h01, 100, cyc, st);
    check("restart_busy_cycles", cyc, 320);
    check("restart_status", st, 8'h02);
    check("restart_data_byte", byte_at(start_idx + 9), 8'hA5);

    // CLKDIV = 0 behaves as 1
    reg_wr(8'h05, 8'h00);
    reg_rd(8'h05, d);
    check("clkdiv0_read", d, 8'h00);
    run_txn(8'h01, 0, cyc, st);
    check("div0_busy_cycles", cyc, 80);
    check("div0_status", st, 8'h02);
    check("div0_data_byte", byte_at(start_idx + 9), 8'hA5);

    // Asynchronous reset in the data phase (WDATA cell for bit 6 = 0, quarter 0)
    reg_wr(8'h05, 8'h04);
    reg_wr(8'h00, 8'h01);
    repeat (177) @(negedge clk);
    check("mid_scl_low", scl_o, 0);
    check("mid_sda_driven", sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_scl", scl_o, 1);
    check("arst_sda_oe", sda_oe, 0);
    @(negedge clk);
    reset = 1'b1;
    reg_rd(8'h04, d);
    check("arst_status", d, 8'h00);
    reg_rd(8'h05, d);
    check("arst_clkdiv", d, 8'h04);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
